// File: rtl/tl_a_arbiter.sv
// Two-master TileLink-UL channel A arbiter with in-order channel D return routing.
// A and D are combinational pass-throughs; a small FIFO remembers who issued each request.

`ifndef TL_ADDR_BITS
`define TL_ADDR_BITS 32
`endif
`ifndef TL_SIZE_BITS
`define TL_SIZE_BITS 3
`endif
`ifndef TL_SOURCE_BITS
`define TL_SOURCE_BITS 4
`endif
`ifndef TL_SINK_BITS
`define TL_SINK_BITS 2
`endif
`ifndef TL_DATA_BYTES
`define TL_DATA_BYTES 4
`endif

module tl_a_arbiter #(
    parameter int ADDR_W     = `TL_ADDR_BITS,
    parameter int SIZE_W     = `TL_SIZE_BITS,
    parameter int SRC_W      = `TL_SOURCE_BITS,
    parameter int SINK_W     = `TL_SINK_BITS,
    parameter int DATA_BYTES = `TL_DATA_BYTES,
    parameter int DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst,

    // master 0, channel A
    input  logic                      m0_a_valid,
    output logic                      m0_a_ready,
    input  logic [2:0]                m0_a_opcode,
    input  logic [2:0]                m0_a_param,
    input  logic [SIZE_W-1:0]         m0_a_size,
    input  logic [SRC_W-1:0]          m0_a_source,
    input  logic [ADDR_W-1:0]         m0_a_address,
    input  logic [DATA_BYTES-1:0]     m0_a_mask,
    input  logic [DATA_BYTES*8-1:0]   m0_a_data,
    // master 0, channel D
    output logic                      m0_d_valid,
    input  logic                      m0_d_ready,
    output logic [3:0]                m0_d_opcode,
    output logic [1:0]                m0_d_param,
    output logic [SIZE_W-1:0]         m0_d_size,
    output logic [SRC_W-1:0]          m0_d_source,
    output logic [SINK_W-1:0]         m0_d_sink,
    output logic                      m0_d_denied,
    output logic [DATA_BYTES*8-1:0]   m0_d_data,

    // master 1, channel A
    input  logic                      m1_a_valid,
    output logic                      m1_a_ready,
    input  logic [2:0]                m1_a_opcode,
    input  logic [2:0]                m1_a_param,
    input  logic [SIZE_W-1:0]         m1_a_size,
    input  logic [SRC_W-1:0]          m1_a_source,
    input  logic [ADDR_W-1:0]         m1_a_address,
    input  logic [DATA_BYTES-1:0]     m1_a_mask,
    input  logic [DATA_BYTES*8-1:0]   m1_a_data,
    // master 1, channel D
    output logic                      m1_d_valid,
    input  logic                      m1_d_ready,
    output logic [3:0]                m1_d_opcode,
    output logic [1:0]                m1_d_param,
    output logic [SIZE_W-1:0]         m1_d_size,
    output logic [SRC_W-1:0]          m1_d_source,
    output logic [SINK_W-1:0]         m1_d_sink,
    output logic                      m1_d_denied,
    output logic [DATA_BYTES*8-1:0]   m1_d_data,

    // shared downstream channel A
    output logic                      s_a_valid,
    input  logic                      s_a_ready,
    output logic [2:0]                s_a_opcode,
    output logic [2:0]                s_a_param,
    output logic [SIZE_W-1:0]         s_a_size,
    output logic [SRC_W-1:0]          s_a_source,
    output logic [ADDR_W-1:0]         s_a_address,
    output logic [DATA_BYTES-1:0]     s_a_mask,
    output logic [DATA_BYTES*8-1:0]   s_a_data,
    // shared downstream channel D
    input  logic                      s_d_valid,
    output logic                      s_d_ready,
    input  logic [3:0]                s_d_opcode,
    input  logic [1:0]                s_d_param,
    input  logic [SIZE_W-1:0]         s_d_size,
    input  logic [SRC_W-1:0]          s_d_source,
    input  logic [SINK_W-1:0]         s_d_sink,
    input  logic                      s_d_denied,
    input  logic [DATA_BYTES*8-1:0]   s_d_data,

    output logic [$clog2(DEPTH):0]    outstanding,
    output logic                      err_unexpected_d
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic          gnt;
    logic          gnt_q;
    logic          lock;
    logic          last;
    logic          sel_valid;
    logic          full;
    logic          empty;
    logic          a_fire;
    logic          d_fire;
    logic          head;
    logic          head_ready;
    logic          err_q;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          fifo_mem [DEPTH];

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // A locked handshake keeps its master; otherwise round-robin away from the last winner.
    always_comb begin
        gnt = 1'b0;
        if (lock)
            gnt = gnt_q;
        else if (m0_a_valid && m1_a_valid)
            gnt = ~last;
        else if (m1_a_valid)
            gnt = 1'b1;
    end

    assign sel_valid  = gnt ? m1_a_valid : m0_a_valid;
    assign s_a_valid  = !rst && sel_valid && !full;
    assign m0_a_ready = !rst && !gnt && s_a_ready && !full;
    assign m1_a_ready = !rst &&  gnt && s_a_ready && !full;
    assign a_fire     = s_a_valid && s_a_ready;

    assign s_a_opcode  = gnt ? m1_a_opcode  : m0_a_opcode;
    assign s_a_param   = gnt ? m1_a_param   : m0_a_param;
    assign s_a_size    = gnt ? m1_a_size    : m0_a_size;
    assign s_a_source  = gnt ? m1_a_source  : m0_a_source;
    assign s_a_address = gnt ? m1_a_address : m0_a_address;
    assign s_a_mask    = gnt ? m1_a_mask    : m0_a_mask;
    assign s_a_data    = gnt ? m1_a_data    : m0_a_data;

    // The slave answers in order, so the FIFO head names the owner of the current response.
    assign head       = fifo_mem[rd_ptr];
    assign head_ready = head ? m1_d_ready : m0_d_ready;
    assign s_d_ready  = !rst && !empty && head_ready;
    assign m0_d_valid = !rst && s_d_valid && !empty && !head;
    assign m1_d_valid = !rst && s_d_valid && !empty &&  head;
    assign d_fire     = s_d_valid && s_d_ready;

    assign m0_d_opcode = s_d_opcode;
    assign m0_d_param  = s_d_param;
    assign m0_d_size   = s_d_size;
    assign m0_d_source = s_d_source;
    assign m0_d_sink   = s_d_sink;
    assign m0_d_denied = s_d_denied;
    assign m0_d_data   = s_d_data;
    assign m1_d_opcode = s_d_opcode;
    assign m1_d_param  = s_d_param;
    assign m1_d_size   = s_d_size;
    assign m1_d_source = s_d_source;
    assign m1_d_sink   = s_d_sink;
    assign m1_d_denied = s_d_denied;
    assign m1_d_data   = s_d_data;

    assign outstanding      = count;
    assign err_unexpected_d = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock   <= 1'b0;
            gnt_q  <= 1'b0;
            last   <= 1'b1;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every update here see pre-edge values.
            if (a_fire) begin
                lock   <= 1'b0;
                last   <= gnt;
                wr_ptr <= wr_ptr + 1'b1;
            end else if (s_a_valid) begin
                lock  <= 1'b1;
                gnt_q <= gnt;
            end

            if (d_fire)
                rd_ptr <= rd_ptr + 1'b1;

            case ({a_fire, d_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (s_d_valid && empty)
                err_q <= 1'b1;
        end
    end

    // NOTE: the ID storage is left unreset; entries are only read once count says they were written.
    always_ff @(posedge clk) begin
        if (a_fire)
            fifo_mem[wr_ptr] <= gnt;
    end

endmodule

// File: doc/tl_a_arbiter.md
Name: tl_a_arbiter

Overview:
- Two-master TileLink-UL arbiter that lets two L1-style masters share a single interconnect master port (m0).
- Arbitrates channel A round-robin and records the issuing master of every granted request in an in-order tracking FIFO.
- Routes channel D responses back to the correct master using that FIFO. The downstream slave (L2 adapter) responds strictly in request order.
- Sits between the L1 adapters and the interconnect m0 port in the top level.

Parameters:
- ADDR_W, `TL_ADDR_BITS, address width
- SIZE_W, `TL_SIZE_BITS, size field width
- SRC_W, `TL_SOURCE_BITS, source field width
- SINK_W, `TL_SINK_BITS, sink field width
- DATA_BYTES, `TL_DATA_BYTES, data bus bytes
- DEPTH, 4, maximum outstanding requests; power of 2, ≥2

Ports:
- clk  in  1  clock, all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- mN_a_valid (N=0,1)  in  1  master N request valid
- mN_a_ready  out  1  master N request accepted
- mN_a_opcode/param  in  3/3  TL A opcode/param
- mN_a_size/source  in  SIZE_W/SRC_W  TL A size/source
- mN_a_address  in  ADDR_W  TL A address
- mN_a_mask/data  in  DATA_BYTES/DATA_BYTES*8  TL A mask/data
- mN_d_valid  out  1  response valid to master N
- mN_d_ready  in  1  master N accepts response
- mN_d_opcode/param  out  4/2  TL D opcode/param
- mN_d_size/source/sink  out  SIZE_W/SRC_W/SINK_W  TL D fields
- mN_d_denied/data  out  1/DATA_BYTES*8  TL D denied/data
- s_a_*  out (ready in)  same set as mN_a_*  shared downstream A channel
- s_d_*  in (ready out)  same set as mN_d_*  shared downstream D channel
- outstanding  out  $clog2(DEPTH)+1  tracking FIFO occupancy, 0..DEPTH
- err_unexpected_d  out  1  sticky: D valid seen while FIFO empty

Behaviour:
- Reset (async, rst=1):
  - FIFO is empty; outstanding=0; lock=0; err_unexpected_d=0.
  - RR pointer last=1, so m0 has priority first.
  - All valid/ready outputs are 0 while rst=1.
- Grant selection, combinational:
  - If lock=1, grant holds the registered gnt.
  - Otherwise, if both masters are valid, grant goes to the master ≠ last. If only one is valid, it gets the grant.
- A path:
  - s_a_valid = granted mN_a_valid & !full.
  - s_a_* payload is a pure mux of the granted master's fields.
  - mN_a_ready = (gnt==N) & s_a_ready & !full; the other master sees ready=0.
- A stability lock:
  - If s_a_valid=1 and s_a_ready=0, set lock=1 and register gnt; hold until A fire.
  - The other master cannot steal the grant mid-handshake, even if higher RR priority.
- A fire (s_a_valid & s_a_ready):
  - Push gnt into the FIFO; last<=gnt; lock<=0.
  - One request per cycle maximum; back-to-back fires are allowed (full throughput).
- Full:
  - When outstanding==DEPTH, s_a_valid=0 and all mN_a_ready=0.
  - This holds even if a D pop occurs in the same cycle; no push-on-pop when full.
- D path:
  - head = FIFO head ID.
  - m(head)_d_valid = s_d_valid & !empty; the other master's d_valid=0.
  - s_d_ready = m(head)_d_ready & !empty.
  - mN_d_* payload is broadcast to both masters; only valid is gated.
  - D fire pops the FIFO.
- Simultaneous push and pop when not full: occupancy is unchanged, and pointers advance modulo DEPTH (wrap-around).
- Empty FIFO with s_d_valid=1: s_d_ready=0 (response stalled), err_unexpected_d<=1 (sticky until reset).
- Latency: zero-cycle combinational pass-through on both A and D; no payload registering.
- Reset mid-transaction: in-flight tracking is lost, so later stray responses set err_unexpected_d.

Test Plan:
- Solo m0 PutFull, addr 0x100, data 0xDEADBEEF, s_a_ready=1:
  - fires in cycle 1 and outstanding=1.
  - AccessAck (opcode 0) is routed only to m0_d_valid; outstanding returns to 0.
- Both masters valid every cycle, s_a_ready=1, responses held off: grants alternate m0,m1,m0,m1 and outstanding reaches 4.
- Full FIFO: a 5th request waits with both mN_a_ready=0; one D pop with m1 valid → m1 fires the following cycle.
- Lock: m1 granted, s_a_ready=0 for 3 cycles while m0 asserts valid → s_a_source stays m1's value throughout; m1 fires when ready=1, then m0 is granted.
- Ordering: issue m1 Get, m0 Get, m1 Get; return AccessAckData (opcode 1) with data 0x11, 0x22, 0x33 → m1 gets 0x11, m0 gets 0x22, m1 gets 0x33.
- D backpressure and error: head=m0 with m0_d_ready=0 → s_d_ready=0 and no pop; s_d_valid with empty FIFO → err_unexpected_d=1 until rst pulse clears it.
